// File: rtl/odometry_pkg.sv
// Shared encodings for the wheel odometry front end: Gray-coded {A,B} states,
// quadrature step codes and the default delta window length.
package odometry_pkg;

   localparam logic [1:0] ST_00 = 2'b00;
   localparam logic [1:0] ST_01 = 2'b01;
   localparam logic [1:0] ST_11 = 2'b11;
   localparam logic [1:0] ST_10 = 2'b10;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_REV  = 2'd2,
      STEP_ILL  = 2'd3
   } step_t;

   // 10 ms window at 50 MHz
   localparam int DEFAULT_SAMPLE_CYCLES = 500000;

   function automatic logic [1:0] next_fwd(input logic [1:0] st);
      logic [1:0] nxt;
      case (st)
         ST_00:   nxt = ST_01;
         ST_01:   nxt = ST_11;
         ST_11:   nxt = ST_10;
         default: nxt = ST_00;
      endcase
      return nxt;
   endfunction

   // A move of two Gray positions cannot be attributed to a direction.
   function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
      step_t s;
      if (cur == prev)
         s = STEP_NONE;
      else if (next_fwd(prev) == cur)
         s = STEP_FWD;
      else if (next_fwd(cur) == prev)
         s = STEP_REV;
      else
         s = STEP_ILL;
      return s;
   endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// One encoder channel: 2-FF synchroniser, plus a stability filter when
// QDEC_GLITCH_FILTER_EN is defined (output follows only FILT_CYCLES equal samples).
module quad_sync_filter #(
   parameter int FILT_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic clean
);
   logic meta;
   logic synced;

   always_ff @(posedge clk) begin
      meta   <= raw;
      synced <= meta;
   end

`ifdef QDEC_GLITCH_FILTER_EN
   localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

   logic [CW-1:0] stable_cnt;
   logic          filt;

   // Counts consecutive samples that disagree with the current output; any
   // agreeing sample restarts the count, so short pulses never propagate.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt       <= synced;
         stable_cnt <= '0;
      end else if (synced == filt) begin
         stable_cnt <= '0;
      end else if (stable_cnt == CW'(FILT_CYCLES - 1)) begin
         filt       <= synced;
         stable_cnt <= '0;
      end else begin
         stable_cnt <= stable_cnt + CW'(1);
      end
   end

   assign clean = filt;
`else
   logic [31:0] unused_cfg;
   assign unused_cfg = 32'(FILT_CYCLES) ^ {31'd0, reset};
   assign clean      = synced;
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// Per-wheel 4x quadrature decoder: signed wrapping position plus a saturated step delta
// per SAMPLE_CYCLES window. Optional input glitch filter under QDEC_GLITCH_FILTER_EN.
//
// db_state | meaning
// ST_00    | A=0 B=0
// ST_01    | A=0 B=1, one forward step after ST_00
// ST_11    | A=1 B=1, two forward steps after ST_00
// ST_10    | A=1 B=0, one reverse step before ST_00
module quadrature_decoder
   import odometry_pkg::*;
#(
   parameter int SAMPLE_CYCLES = DEFAULT_SAMPLE_CYCLES,
   parameter int CNT_W         = 32,
   parameter int DELTA_W       = 16,
   parameter int FILT_CYCLES   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      A,
   input  logic                      B,
   input  logic                      clear_count,
   output logic signed [CNT_W-1:0]   position,
   output logic signed [DELTA_W-1:0] delta,
   output logic                      delta_valid,
   output logic                      direction,
   output logic                      quad_error,
   output logic [1:0]                db_state
);
   // Two guard bits let the window total overshoot the delta range before clipping.
   localparam int AW = DELTA_W + 2;
   localparam int TW = $clog2(SAMPLE_CYCLES);

   localparam logic [TW-1:0]      TIMER_LAST = TW'(SAMPLE_CYCLES - 1);
   localparam logic [AW-1:0]      ACC_MAX    = {1'b0, {(AW-1){1'b1}}};
   localparam logic [AW-1:0]      ACC_MIN    = {1'b1, {(AW-1){1'b0}}};
   localparam logic [DELTA_W-1:0] DELTA_MAX  = {1'b0, {(DELTA_W-1){1'b1}}};
   localparam logic [DELTA_W-1:0] DELTA_MIN  = {1'b1, {(DELTA_W-1){1'b0}}};

   logic                  a_dec;
   logic                  b_dec;
   logic [1:0]            cur_state;
   step_t                 step;
   logic                  terminal;
   logic [TW-1:0]         timer;
   logic signed [AW-1:0]  accum;
   logic signed [AW-1:0]  accum_next;
   logic signed [AW-1:0]  step_inc;
   logic [DELTA_W-1:0]    delta_next;

   quad_sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_sync_a (
      .clk   (clk),
      .reset (reset),
      .raw   (A),
      .clean (a_dec)
   );

   quad_sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_sync_b (
      .clk   (clk),
      .reset (reset),
      .raw   (B),
      .clean (b_dec)
   );

   always_comb begin
      cur_state  = {a_dec, b_dec};
      step       = decode_step(db_state, cur_state);
      terminal   = (timer == TIMER_LAST);
      step_inc   = '0;
      accum_next = accum;
      case (step)
         STEP_FWD: begin
            step_inc = AW'(1);
            if (accum != ACC_MAX)
               accum_next = accum + AW'(1);
         end
         STEP_REV: begin
            step_inc = '1;
            if (accum != ACC_MIN)
               accum_next = accum - AW'(1);
         end
         default: ;
      endcase

      // Fits when the guard bits are a pure sign extension.
      if (accum[AW-1:DELTA_W-1] == '0 || accum[AW-1:DELTA_W-1] == '1)
         delta_next = accum[DELTA_W-1:0];
      else if (accum[AW-1])
         delta_next = DELTA_MIN;
      else
         delta_next = DELTA_MAX;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         db_state    <= cur_state;
         position    <= '0;
         delta       <= '0;
         delta_valid <= 1'b0;
         direction   <= 1'b1;
         quad_error  <= 1'b0;
         timer       <= '0;
         accum       <= '0;
      end else begin
         db_state    <= cur_state;
         delta_valid <= 1'b0;
         if (clear_count) begin
            position   <= '0;
            accum      <= '0;
            timer      <= '0;
            quad_error <= 1'b0;
         end else begin
            case (step)
               STEP_FWD: begin
                  position  <= position + CNT_W'(1);
                  direction <= 1'b1;
               end
               STEP_REV: begin
                  position  <= position - CNT_W'(1);
                  direction <= 1'b0;
               end
               STEP_ILL: quad_error <= 1'b1;
               default: ;
            endcase

            // The step seen on the terminal cycle opens the next window.
            if (terminal) begin
               timer       <= '0;
               delta       <= delta_next;
               delta_valid <= 1'b1;
               accum       <= step_inc;
            end else begin
               timer <= timer + TW'(1);
               accum <= accum_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: a wide instance and a narrow one (wrap/saturation)
// share the same encoder stimulus and are checked at every delta_valid against an event model.
`timescale 1ns/1ps
module tb_quadrature_decoder;

   localparam int S    = 16;
   localparam int FILT = 4;
`ifdef QDEC_GLITCH_FILTER_EN
   localparam int F   = FILT;
   localparam int GAP = FILT;
`else
   localparam int F   = 0;
   localparam int GAP = 1;
`endif
   // pin change after edge n is seen by the step logic at edge n + LAT
   localparam int LAT = 3 + F;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic A = 1'b0;
   logic B = 1'b0;
   logic clear_count = 1'b0;

   logic signed [31:0] position;
   logic signed [15:0] delta;
   logic               delta_valid, direction, quad_error;
   logic [1:0]         db_state;
   logic signed [2:0]  position_n;
   logic signed [2:0]  delta_n;
   logic               delta_valid_n, direction_n, quad_error_n;
   logic [1:0]         db_state_n;

   quadrature_decoder #(.SAMPLE_CYCLES(S), .CNT_W(32), .DELTA_W(16), .FILT_CYCLES(FILT)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .clear_count(clear_count),
      .position(position), .delta(delta), .delta_valid(delta_valid),
      .direction(direction), .quad_error(quad_error), .db_state(db_state)
   );

   quadrature_decoder #(.SAMPLE_CYCLES(S), .CNT_W(3), .DELTA_W(3), .FILT_CYCLES(FILT)) dut_n (
      .clk(clk), .reset(reset), .A(A), .B(B), .clear_count(clear_count),
      .position(position_n), .delta(delta_n), .delta_valid(delta_valid_n),
      .direction(direction_n), .quad_error(quad_error_n), .db_state(db_state_n)
   );

   always #5 clk = ~clk;

   typedef struct { int e; logic [1:0] ab; } ev_t;
   typedef struct { int e; int dsum; longint pos; bit dir; bit err; } exp_t;

   ev_t    evq[$];
   exp_t   expq[$];
   int     cyc = 0;
   int     m_base = 0;
   bit     m_alive = 1'b0;
   int     m_sum = 0;
   longint m_pos = 0;
   bit     m_dir = 1'b1;
   bit     m_err = 1'b0;
   logic [1:0] m_prev = 2'b00;
   int     cur_idx = 0;
   int     checks = 0;
   int     errors = 0;

   function automatic int gidx(logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gcode(int i);
      case (i % 4)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic longint sat(longint v, int w);
      longint hi = (64'sd1 <<< (w - 1)) - 1;
      longint lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint wrap(longint v, int w);
      longint m = v & ((64'sd1 <<< w) - 1);
      if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
      return m;
   endfunction

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: steps land LAT edges after the pin change; windows are S edges long
   // starting the edge after reset/clear; a step on a window's last edge opens the next window.
   initial forever begin
      int d;
      bit ill;
      int g;
      @(posedge clk);
      cyc++;
      if (reset) begin
         m_alive = 1'b1;
         m_base  = cyc + 1;
         m_sum   = 0;
         m_pos   = 0;
         m_dir   = 1'b1;
         m_err   = 1'b0;
         m_prev  = {A, B};
         evq.delete();
      end else if (m_alive) begin
         d   = 0;
         ill = 1'b0;
         while (evq.size() > 0 && evq[0].e == cyc) begin
            g = (gidx(evq[0].ab) - gidx(m_prev) + 4) % 4;
            if (g == 1) d = d + 1;
            else if (g == 3) d = d - 1;
            else if (g == 2) ill = 1'b1;
            m_prev = evq[0].ab;
            void'(evq.pop_front());
         end
         if (clear_count) begin
            m_pos  = 0;
            m_err  = 1'b0;
            m_sum  = 0;
            m_base = cyc + 1;
         end else begin
            if (ill) m_err = 1'b1;
            else if (d != 0) begin
               m_pos = m_pos + d;
               m_dir = (d > 0);
            end
            if ((cyc - m_base) % S == S - 1) begin
               expq.push_back('{cyc, m_sum, m_pos, m_dir, m_err});
               m_sum = d;
            end else begin
               m_sum = m_sum + d;
            end
         end
      end
   end

   // Monitor: every delta_valid pops one expected window result.
   initial forever begin
      exp_t x;
      @(negedge clk);
      if (delta_valid || delta_valid_n) begin
         chk("valid_pair", 64'(delta_valid_n), 64'(delta_valid));
         if (expq.size() == 0) begin
            chk("unexpected_valid", 64'(delta_valid | delta_valid_n), 0);
         end else begin
            x = expq.pop_front();
            chk("valid_cycle", cyc, x.e);
            chk("delta", delta, sat(x.dsum, 16));
            chk("delta_n", delta_n, sat(x.dsum, 3));
            chk("position", position, wrap(x.pos, 32));
            chk("position_n", position_n, wrap(x.pos, 3));
            chk("direction", 64'(direction), 64'(x.dir));
            chk("direction_n", 64'(direction_n), 64'(x.dir));
            chk("quad_error", 64'(quad_error), 64'(x.err));
            chk("quad_error_n", 64'(quad_error_n), 64'(x.err));
         end
      end
      if (expq.size() > 0 && expq[0].e < cyc) begin
         chk("missed_valid", 64'(delta_valid), 1);
         void'(expq.pop_front());
      end
   end

   task automatic drive(input logic [1:0] ab, input bit counted);
      if (counted) evq.push_back('{cyc + LAT, ab});
      {A, B} = ab;
   endtask

   task automatic step(input bit fwd, input int hold);
      cur_idx = (cur_idx + (fwd ? 1 : 3)) % 4;
      drive(gcode(cur_idx), 1'b1);
      repeat (hold) @(negedge clk);
   endtask

   task automatic jump(input int hold);
      cur_idx = (cur_idx + 2) % 4;
      drive(gcode(cur_idx), 1'b1);
      repeat (hold) @(negedge clk);
   endtask

   // Two-cycle pulse on A: visible as two steps without the filter, swallowed with it.
   task automatic glitch_a();
      drive(gcode(cur_idx) ^ 2'b10, F == 0);
      repeat (2) @(negedge clk);
      drive(gcode(cur_idx), F == 0);
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic do_clear();
      clear_count = 1'b1;
      @(negedge clk);
      clear_count = 1'b0;
   endtask

   task automatic settle();
      repeat (LAT + 4) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_position"}, position, 0);
      chk({tag, "_delta"}, delta, 0);
      chk({tag, "_delta_valid"}, 64'(delta_valid), 0);
      chk({tag, "_direction"}, 64'(direction), 1);
      chk({tag, "_quad_error"}, 64'(quad_error), 0);
      chk({tag, "_position_n"}, position_n, 0);
      chk({tag, "_quad_error_n"}, 64'(quad_error_n), 0);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check_reset_outputs("rst0");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("db_state", 64'(db_state), 64'({A, B}));
      chk("db_state_n", 64'(db_state_n), 64'({A, B}));

      repeat (40) step(1'b1, 8);
      settle();
      do_clear();

      repeat (20) step(1'b1, 8);
      repeat (12) step(1'b0, 8);
      settle();
      do_clear();

      repeat (16) step(1'b1, 4);
      settle();

      jump(8);
      repeat (4) step(1'b1, 8);
      settle();
      repeat (S) @(negedge clk);
      do_clear();
      repeat (S + 2) @(negedge clk);

      // land a step exactly on a window's terminal cycle
      for (int i = 0; i < S && ((cyc + LAT - m_base) % S) != S - 1; i++) @(negedge clk);
      step(1'b1, 2 * S);

      // step and clear evaluated on the same edge
      step(1'b1, 0);
      repeat (LAT - 1) @(negedge clk);
      do_clear();
      settle();

      glitch_a();
      settle();

      repeat (40) step(1'b1, GAP);
      settle();
      repeat (40) step(1'b0, GAP);
      settle();

      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 31);
         if (r == 0) jump(GAP + $urandom_range(0, 4));
         else if (r == 1) do_clear();
         else if (r == 2) glitch_a();
         else step(1'($urandom_range(0, 1)), GAP + $urandom_range(0, 6));
      end
      settle();

      // reset in the middle of a window discards it without a delta_valid
      step(1'b1, GAP);
      step(1'b1, GAP);
      settle();
      for (int i = 0; i < S && ((cyc - m_base) % S) != S / 2; i++) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst1");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      repeat (6) step(1'b0, GAP + 2);

      settle();
      repeat (2 * S + 2) @(negedge clk);
      chk("pending_expect", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
